// File: rtl/rtc_access_scheduler_pkg.sv
// Shared definitions for the RTC bus access scheduler: state encoding,
// RTC field indices and default slot lengths.
package rtc_access_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_GO   = 3'd1,
        RD_WAIT = 3'd2,
        WR_GO   = 3'd3,
        WR_WAIT = 3'd4
    } state_t;

    // Field-read engine indices
    localparam logic [2:0] SEG  = 3'd0;
    localparam logic [2:0] MIN  = 3'd1;
    localparam logic [2:0] HORA = 3'd2;
    localparam logic [2:0] DIA  = 3'd3;
    localparam logic [2:0] MES  = 3'd4;
    localparam logic [2:0] ANIO = 3'd5;

    localparam int DEF_SLOT_LEN    = 36;
    localparam int DEF_WR_SLOT_LEN = 36;

endpackage

// File: rtl/rtc_access_scheduler_slot_timer.sv
// Slot timer: cleared when a slot starts, counts while the bus is busy and
// flags the last cycle of the slot.
module slot_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       run,
    input  logic [7:0] len_m1,
    output logic       done
);

    logic [7:0] cnt;

    // Count register: cleared on slot entry, advances every busy cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     cnt <= 8'd0;
        else if (load) cnt <= 8'd0;
        else if (run)  cnt <= cnt + 8'd1;
    end

    assign done = run && (cnt == len_m1);

endmodule

// File: rtl/rtc_access_scheduler.sv
// Arbitrates the shared RTC bus between periodic field-read scans and
// write requests. Writes preempt a scan at slot boundaries; the scan then
// resumes at the next field. Slots are issued back to back.
module rtc_access_scheduler
    import rtc_access_scheduler_pkg::*;
#(
    parameter int N_FIELDS    = 6,
    parameter int SLOT_LEN    = DEF_SLOT_LEN,
    parameter int WR_SLOT_LEN = DEF_WR_SLOT_LEN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                tick,
    input  logic                wr_req,
    output logic [N_FIELDS-1:0] rd_go,
    output logic                wr_go,
    output logic                wr_ack,
    output logic                bus_busy,
    output logic [2:0]          field_idx,
    output logic                scan_done,
    output logic                overrun
);

    localparam logic [7:0] RD_LEN_M1 = 8'(SLOT_LEN - 1);
    localparam logic [7:0] WR_LEN_M1 = 8'(WR_SLOT_LEN - 1);
    localparam logic [2:0] LAST_FLD  = 3'(N_FIELDS - 1);

    state_t     state, state_d;
    logic [2:0] fidx, fidx_d;
    logic       pending, pending_d;
    logic       intr, intr_d;
    logic       done_d;
    logic       armed;
    logic       slot_done, load, tick_v, start, abandon;
    logic       rd_slot, wr_slot;

    assign rd_slot = (state == RD_GO) || (state == RD_WAIT);
    assign wr_slot = (state == WR_GO) || (state == WR_WAIT);
    assign tick_v  = tick && enable;

    slot_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .run    (bus_busy),
        .len_m1 (wr_slot ? WR_LEN_M1 : RD_LEN_M1),
        .done   (slot_done)
    );

    // State, field index, pending/interrupted flags and scan_done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fidx      <= 3'd0;
            pending   <= 1'b0;
            intr      <= 1'b0;
            scan_done <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_d;
            fidx      <= fidx_d;
            pending   <= pending_d;
            intr      <= intr_d;
            scan_done <= done_d;
            armed     <= 1'b1;
        end
    end

    // Next-state selection at idle and at slot boundaries
    always_comb begin
        state_d   = state;
        fidx_d    = fidx;
        intr_d    = intr;
        done_d    = 1'b0;
        start     = 1'b0;
        abandon   = 1'b0;
        case (state)
            IDLE: begin
                // armed holds off slot starts at the first edge after reset
                if (enable && armed) begin
                    if (wr_req) begin
                        state_d = WR_GO;
                    end else if (tick || pending) begin
                        state_d = RD_GO;
                        fidx_d  = 3'd0;
                        start   = 1'b1;
                    end
                end
            end
            RD_GO: state_d = RD_WAIT;
            RD_WAIT: begin
                if (slot_done) begin
                    if (!enable) begin
                        abandon = 1'b1;
                    end else begin
                        if (fidx == LAST_FLD) done_d = 1'b1;
                        if (wr_req) begin
                            state_d = WR_GO;
                            // a write after the last field leaves nothing to resume
                            if (fidx == LAST_FLD) fidx_d = 3'd0;
                            else                  intr_d = 1'b1;
                        end else if (fidx != LAST_FLD) begin
                            state_d = RD_GO;
                            fidx_d  = fidx + 3'd1;
                        end else begin
                            state_d = IDLE;
                            fidx_d  = 3'd0;
                        end
                    end
                end
            end
            WR_GO: state_d = WR_WAIT;
            WR_WAIT: begin
                if (slot_done) begin
                    if (!enable) begin
                        abandon = 1'b1;
                    end else if (intr) begin
                        state_d = RD_GO;
                        fidx_d  = fidx + 3'd1;
                        intr_d  = 1'b0;
                    end else if (wr_req) begin
                        state_d = WR_GO;
                    end else if (tick || pending) begin
                        state_d = RD_GO;
                        fidx_d  = 3'd0;
                        start   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abandon) begin
            state_d = IDLE;
            fidx_d  = 3'd0;
            intr_d  = 1'b0;
        end
    end

    // Pending scan: a new scan start consumes it, a qualified tick sets it
    always_comb begin
        pending_d = pending;
        if (abandon || start) pending_d = 1'b0;
        else if (tick_v)      pending_d = 1'b1;
    end

    // Load the slot timer on entry to either go state
    always_comb begin
        load = (state_d == RD_GO) || (state_d == WR_GO);
    end

    assign rd_go     = (state == RD_GO) ? ({{(N_FIELDS-1){1'b0}}, 1'b1} << fidx) : '0;
    assign wr_go     = (state == WR_GO);
    assign wr_ack    = wr_go;
    assign bus_busy  = (state != IDLE);
    assign field_idx = rd_slot ? fidx : 3'd0;
    assign overrun   = tick_v && pending;

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Scenario bench for rtc_access_scheduler: expected bus events are queued
// as stimulus is applied and compared against events seen on the outputs.
module tb_rtc_access_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       tick;
    logic       wr_req;
    logic [5:0] rd_go;
    logic       wr_go, wr_ack, bus_busy, scan_done, overrun;
    logic [2:0] field_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  kind;   // 1 rd_go, 2 wr_go, 3 scan_done, 4 overrun
        logic [15:0] val;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t m_ev;

    rtc_access_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .tick      (tick),
        .wr_req    (wr_req),
        .rd_go     (rd_go),
        .wr_go     (wr_go),
        .wr_ack    (wr_ack),
        .bus_busy  (bus_busy),
        .field_idx (field_idx),
        .scan_done (scan_done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: record every event pulse with its cycle number
    always @(negedge clk) begin
        if (!reset) begin
            m_ev.cyc = cyc;
            if (rd_go != 6'd0) begin
                m_ev.kind = 8'd1; m_ev.val = {7'd0, field_idx, rd_go}; obs_q.push_back(m_ev);
            end
            if (wr_go || wr_ack) begin
                m_ev.kind = 8'd2; m_ev.val = {14'd0, wr_go, wr_ack}; obs_q.push_back(m_ev);
            end
            if (scan_done) begin
                m_ev.kind = 8'd3; m_ev.val = 16'd1; obs_q.push_back(m_ev);
            end
            if (overrun) begin
                m_ev.kind = 8'd4; m_ev.val = 16'd1; obs_q.push_back(m_ev);
            end
            if (bus_busy) busy_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int c, input int kind, input int fld);
        ev_t e;
        logic [5:0] oh;
        e.cyc  = c;
        e.kind = 8'(kind);
        oh     = 6'd1 << fld;
        case (kind)
            1:       e.val = {7'd0, 3'(fld), oh};
            2:       e.val = 16'd3;
            default: e.val = 16'd1;
        endcase
        exp_q.push_back(e);
    endtask

    task automatic push_scan(input int t, input int first_fld);
        for (int f = first_fld; f < 6; f++) push_ev(t + 36 * (f - first_fld), 1, f);
    endtask

    task automatic clear_obs;
        obs_q.delete();
        exp_q.delete();
        busy_cnt = 0;
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; tick = 1'b0; wr_req = 1'b0;
        step(3);
        checks++; if (rd_go !== 6'd0)   begin $display("FAIL reset_rd_go: got %h want 0", rd_go); errors++; end
        checks++; if (wr_go !== 1'b0)   begin $display("FAIL reset_wr_go: got %b want 0", wr_go); errors++; end
        checks++; if (bus_busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", bus_busy); errors++; end
        checks++; if (field_idx !== 3'd0) begin $display("FAIL reset_fidx: got %0d want 0", field_idx); errors++; end
        checks++; if ({scan_done, overrun, wr_ack} !== 3'b000) begin
            $display("FAIL reset_pulses: got %b want 000", {scan_done, overrun, wr_ack}); errors++;
        end
        reset = 1'b0;
        step(4);
        checks++; if (bus_busy !== 1'b0) begin $display("FAIL post_reset_busy: got %b want 0", bus_busy); errors++; end
    endtask

    task automatic test_scan;
        int t0;
        ev_t e, o;
        clear_obs();
        t0 = cyc;
        tick = 1'b1;
        push_scan(t0 + 1, 0);
        push_ev(t0 + 217, 3, 0);
        step(1); tick = 1'b0;
        step(225);
        checks++; if (busy_cnt != 216) begin $display("FAIL scan_busy: got %0d want 216", busy_cnt); errors++; end
        checks++; if (obs_q.size() != exp_q.size()) begin
            $display("FAIL scan_count: got %0d want %0d", obs_q.size(), exp_q.size()); errors++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                $display("FAIL scan_ev: got cyc=%0d kind=%0d val=%h want cyc=%0d kind=%0d val=%h",
                         o.cyc, o.kind, o.val, e.cyc, e.kind, e.val); errors++;
            end
        end
    endtask

    task automatic test_write;
        int t0;
        ev_t e, o;
        clear_obs();
        t0 = cyc;
        wr_req = 1'b1;
        push_ev(t0 + 1, 2, 0);
        step(1);
        checks++; if (wr_ack !== 1'b1) begin $display("FAIL wr_ack: got %b want 1", wr_ack); errors++; end
        wr_req = 1'b0;
        step(35);
        checks++; if (bus_busy !== 1'b1) begin $display("FAIL wr_busy_last: got %b want 1", bus_busy); errors++; end
        step(1);
        checks++; if (bus_busy !== 1'b0) begin $display("FAIL wr_idle: got %b want 0", bus_busy); errors++; end
        step(4);
        checks++; if (busy_cnt != 36) begin $display("FAIL wr_busy: got %0d want 36", busy_cnt); errors++; end
        checks++; if (obs_q.size() != exp_q.size()) begin
            $display("FAIL wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); errors++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                $display("FAIL wr_ev: got cyc=%0d kind=%0d val=%h want cyc=%0d kind=%0d val=%h",
                         o.cyc, o.kind, o.val, e.cyc, e.kind, e.val); errors++;
            end
        end
    endtask

    task automatic test_interrupt;
        int t0;
        bit seen;
        ev_t e, o;
        clear_obs();
        t0 = cyc;
        tick = 1'b1;
        push_ev(t0 + 1, 1, 0); push_ev(t0 + 37, 1, 1); push_ev(t0 + 73, 1, 2);
        push_ev(t0 + 109, 2, 0);
        push_ev(t0 + 145, 1, 3); push_ev(t0 + 181, 1, 4); push_ev(t0 + 217, 1, 5);
        push_ev(t0 + 253, 3, 0);
        step(1); tick = 1'b0;
        step(79);
        checks++; if (field_idx !== 3'd2) begin $display("FAIL int_fidx: got %0d want 2", field_idx); errors++; end
        wr_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step(1);
            if (wr_go) seen = 1'b1;
        end
        wr_req = 1'b0;
        checks++; if (!seen) begin $display("FAIL int_wr_timeout: got no wr_go want wr_go"); errors++; end
        step(180);
        checks++; if (busy_cnt != 252) begin $display("FAIL int_busy: got %0d want 252", busy_cnt); errors++; end
        checks++; if (obs_q.size() != exp_q.size()) begin
            $display("FAIL int_count: got %0d want %0d", obs_q.size(), exp_q.size()); errors++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                $display("FAIL int_ev: got cyc=%0d kind=%0d val=%h want cyc=%0d kind=%0d val=%h",
                         o.cyc, o.kind, o.val, e.cyc, e.kind, e.val); errors++;
            end
        end
    endtask

    task automatic test_overrun;
        int t0;
        ev_t e, o;
        clear_obs();
        t0 = cyc;
        tick = 1'b1;
        push_scan(t0 + 1, 0);
        step(1); tick = 1'b0;
        step(9);  tick = 1'b1; step(1); tick = 1'b0;
        step(9);  tick = 1'b1; push_ev(t0 + 20, 4, 0); step(1); tick = 1'b0;
        step(9);  tick = 1'b1; push_ev(t0 + 30, 4, 0); step(1); tick = 1'b0;
        push_ev(t0 + 217, 3, 0);
        push_scan(t0 + 218, 0);
        push_ev(t0 + 434, 3, 0);
        step(410);
        checks++; if (busy_cnt != 432) begin $display("FAIL ovr_busy: got %0d want 432", busy_cnt); errors++; end
        checks++; if (obs_q.size() != exp_q.size()) begin
            $display("FAIL ovr_count: got %0d want %0d", obs_q.size(), exp_q.size()); errors++;
        end
        // events are queued in stimulus order; sort both by cycle to compare
        exp_q.sort() with (item.cyc);
        obs_q.sort() with (item.cyc);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                $display("FAIL ovr_ev: got cyc=%0d kind=%0d val=%h want cyc=%0d kind=%0d val=%h",
                         o.cyc, o.kind, o.val, e.cyc, e.kind, e.val); errors++;
            end
        end
    endtask

    task automatic test_tick_write_together;
        int t0;
        ev_t e, o;
        clear_obs();
        t0 = cyc;
        tick = 1'b1; wr_req = 1'b1;
        push_ev(t0 + 1, 2, 0);
        push_scan(t0 + 37, 0);
        push_ev(t0 + 253, 3, 0);
        step(1); tick = 1'b0; wr_req = 1'b0;
        step(260);
        checks++; if (busy_cnt != 252) begin $display("FAIL tw_busy: got %0d want 252", busy_cnt); errors++; end
        checks++; if (obs_q.size() != exp_q.size()) begin
            $display("FAIL tw_count: got %0d want %0d", obs_q.size(), exp_q.size()); errors++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                $display("FAIL tw_ev: got cyc=%0d kind=%0d val=%h want cyc=%0d kind=%0d val=%h",
                         o.cyc, o.kind, o.val, e.cyc, e.kind, e.val); errors++;
            end
        end
    endtask

    task automatic test_reset_mid;
        int t0;
        ev_t e, o;
        clear_obs();
        t0 = cyc;
        tick = 1'b1;
        for (int f = 0; f < 5; f++) push_ev(t0 + 1 + 36 * f, 1, f);
        step(1); tick = 1'b0;
        step(149);
        checks++; if (field_idx !== 3'd4) begin $display("FAIL rm_pre_fidx: got %0d want 4", field_idx); errors++; end
        reset = 1'b1;
        #1;
        checks++; if ({rd_go, wr_go, wr_ack, bus_busy, field_idx, scan_done, overrun} !== 16'd0) begin
            $display("FAIL rm_outputs: got %h want 0",
                     {rd_go, wr_go, wr_ack, bus_busy, field_idx, scan_done, overrun}); errors++;
        end
        step(2);
        reset = 1'b0;
        step(3);
        t0 = cyc;
        tick = 1'b1;
        push_scan(t0 + 1, 0);
        push_ev(t0 + 217, 3, 0);
        step(1); tick = 1'b0;
        step(222);
        checks++; if (obs_q.size() != exp_q.size()) begin
            $display("FAIL rm_count: got %0d want %0d", obs_q.size(), exp_q.size()); errors++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                $display("FAIL rm_ev: got cyc=%0d kind=%0d val=%h want cyc=%0d kind=%0d val=%h",
                         o.cyc, o.kind, o.val, e.cyc, e.kind, e.val); errors++;
            end
        end
    endtask

    task automatic test_enable_drop;
        int t0;
        ev_t e, o;
        clear_obs();
        t0 = cyc;
        tick = 1'b1;
        push_ev(t0 + 1, 1, 0); push_ev(t0 + 37, 1, 1);
        step(1); tick = 1'b0;
        step(39); enable = 1'b0;
        step(60);
        // tick while disabled must be ignored entirely
        tick = 1'b1; step(1); tick = 1'b0;
        step(9); enable = 1'b1;
        step(20);
        checks++; if (busy_cnt != 72) begin $display("FAIL en_busy: got %0d want 72", busy_cnt); errors++; end
        checks++; if (bus_busy !== 1'b0) begin $display("FAIL en_idle: got %b want 0", bus_busy); errors++; end
        checks++; if (obs_q.size() != exp_q.size()) begin
            $display("FAIL en_count: got %0d want %0d", obs_q.size(), exp_q.size()); errors++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                $display("FAIL en_ev: got cyc=%0d kind=%0d val=%h want cyc=%0d kind=%0d val=%h",
                         o.cyc, o.kind, o.val, e.cyc, e.kind, e.val); errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_write();
        test_interrupt();
        test_overrun();
        test_tick_write_together();
        test_reset_mid();
        test_enable_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
